// File: rtl/spi_bridge.sv
// spi_bridge: SPI mode-0 slave front end for the instruction decoder.
// Oversamples sclk/cs_n/mosi in the clk domain, assembles MSB-first bytes,
// pulses byte_sync per completed byte, and shifts data_out back on miso.
module spi_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise;
  logic                   fall;
  logic                   cs_fall;

  logic [CNT_W-1:0]       bit_cnt,   bit_cnt_d;
  logic [BYTE_W-1:0]      rx_shift,  rx_shift_d;
  logic [BYTE_W-1:0]      tx_shift,  tx_shift_d;
  logic [BYTE_W-1:0]      data_in_d;
  logic                   load_pend, load_pend_d;
  logic                   byte_sync_d;
  logic                   miso_d;

  // Input synchronizers; cs_n chain resets to the deselected level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_q;
  assign fall    = ~sclk_s & sclk_q;
  assign cs_fall = ~cs_s & cs_q;

  // Next-state for receive/transmit shifters, bit counter and byte handoff.
  always_comb begin
    bit_cnt_d   = bit_cnt;
    rx_shift_d  = rx_shift;
    tx_shift_d  = tx_shift;
    data_in_d   = data_in;
    load_pend_d = 1'b0;
    byte_sync_d = 1'b0;
    if (cs_s) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else begin
      load_pend_d = byte_sync;
      if (rise) begin
        rx_shift_d = {rx_shift[BYTE_W-2:0], mosi_s};
        bit_cnt_d  = CNT_W'(bit_cnt + CNT_W'(1));
        if (bit_cnt == CNT_W'(7)) begin
          data_in_d   = rx_shift_d;
          byte_sync_d = 1'b1;
        end
      end
      // Frame start forces 0x00; a pending decoder load beats a shift; the
      // fall right after a byte boundary (bit_cnt 0) keeps the new MSB.
      if (cs_fall) begin
        tx_shift_d = '0;
      end else if (load_pend) begin
        tx_shift_d = data_out;
      end else if (fall && (bit_cnt != '0)) begin
        tx_shift_d = {tx_shift[BYTE_W-2:0], 1'b0};
      end
    end
    // Registered miso equals the next cycle's ~cs_s & tx_shift[7].
    miso_d = ~cs_sync[SYNC_STAGES-2] & tx_shift_d[BYTE_W-1];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      load_pend <= 1'b0;
      data_in   <= '0;
      byte_sync <= 1'b0;
      miso      <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_d;
      rx_shift  <= rx_shift_d;
      tx_shift  <= tx_shift_d;
      load_pend <= load_pend_d;
      data_in   <= data_in_d;
      byte_sync <= byte_sync_d;
      miso      <= miso_d;
    end
  end

endmodule

// File: tb/tb_spi_bridge.sv
// Bench for spi_bridge: an SPI mode-0 master model drives directed frames,
// received bytes are queued as expectations and checked by a byte_sync monitor.
module tb_spi_bridge;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int unsigned checks;
  int unsigned passes;
  logic [7:0]  exp_q[$];
  logic        prev_bs;

  spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .byte_sync(byte_sync),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every byte_sync pulse must be one clk wide and match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bs = 1'b0;
    end else begin
      if (byte_sync) begin
        chk("bs_width", 8'(prev_bs), 8'h00);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte_sync: got data_in %h expected no pulse at %0t", data_in, $time);
        end else begin
          chk("data_in", data_in, exp_q.pop_front());
        end
      end
      prev_bs = byte_sync;
    end
  end

  // One MSB-first byte: mosi changes while sclk low, miso sampled at the rise.
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      wait_clk(4);
      got[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] m0, input logic [7:0] m1);
    logic [7:0] got;
    cs_n = 1'b0;
    wait_clk(4);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(k == 0 ? b0 : b1);
      spi_byte(k == 0 ? b0 : b1, got);
      chk("miso_byte", got, k == 0 ? m0 : m1);
    end
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic partial_bits(input int n);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    prev_bs  = 1'b0;
    rst_n    = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    data_out = 8'h00;
    wait_clk(3);
    chk("rst_miso", 8'(miso), 8'h00);
    chk("rst_byte_sync", 8'(byte_sync), 8'h00);
    chk("rst_data_in", data_in, 8'h00);
    rst_n = 1'b1;
    wait_clk(4);

    // Single byte, first byte of a frame returns 0x00.
    spi_frame(1, 8'hA5, 8'h00, 8'h00, 8'h00);

    // Two-byte frame, decoder answers 0x3C on the second byte.
    data_out = 8'h3C;
    spi_frame(2, 8'h05, 8'h00, 8'h00, 8'h3C);

    // Abort after 5 bits, then a full byte.
    partial_bits(5);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
    spi_frame(1, 8'h81, 8'h00, 8'h00, 8'h00);

    // sclk activity while deselected changes nothing.
    for (int i = 0; i < 16; i++) begin
      sclk = ~sclk;
      wait_clk(4);
      chk("idle_miso", 8'(miso), 8'h00);
    end
    sclk = 1'b0;
    wait_clk(4);
    chk("idle_data_in", data_in, 8'h81);

    // Back-to-back frames.
    data_out = 8'h5A;
    spi_frame(2, 8'h80, 8'h11, 8'h00, 8'h5A);
    data_out = 8'hC3;
    spi_frame(2, 8'h00, 8'h00, 8'h00, 8'hC3);

    // Reset in the middle of a byte after a nonzero byte was received.
    spi_frame(1, 8'h7E, 8'h00, 8'h00, 8'h00);
    data_out = 8'hFF;
    partial_bits(4);
    rst_n = 1'b0;
    #2;
    chk("midrst_miso", 8'(miso), 8'h00);
    chk("midrst_byte_sync", 8'(byte_sync), 8'h00);
    chk("midrst_data_in", data_in, 8'h00);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    chk("post_rst_data_in", data_in, 8'h00);
    chk("post_rst_miso", 8'(miso), 8'h00);
    spi_frame(2, 8'h33, 8'hC9, 8'h00, 8'hFF);

    wait_clk(10);
    chk("pending_bytes", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
